mult_unit: RTL and testbench
============================

Name: mult_unit

Overview:
- Iterative 32x32 -> 64-bit multiplier for the MIPS execute stage; backs MULT/MULTU and writes the HI/LO pair.
- Radix-2 shift-add: one 32-bit add with carry-out per cycle, plus a sign-correction cycle.
- Sits beside the ALU adder. The execute stage stalls while o_busy is high.

Parameters:
- WIDTH, 32, operand width. The counter and state are sized from it. Only 32 is verified.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_start  input  1  request. Sampled only in IDLE.
- i_signed  input  1  1 = MULT (two's complement), 0 = MULTU.
- i_op1  input  WIDTH  multiplicand. Captured on the accepting edge.
- i_op2  input  WIDTH  multiplier. Captured on the accepting edge.
- o_busy  output  1  operation in flight.
- o_done  output  1  one-cycle pulse: o_hi/o_lo are valid.
- o_hi  output  WIDTH  upper product half (HI).
- o_lo  output  WIDTH  lower product half (LO).

Behaviour:
- Clock and reset: one clock, i_clk; reset is synchronous and active-high, i_rst.
- Reset values: state=IDLE; o_busy=0, o_done=0, o_hi=0, o_lo=0; counter=0.
- Reset dominates every other input. Reset mid-operation aborts, clears all outputs, and produces no o_done.

States:
- IDLE:
  - i_start=1 on edge 0 latches operands, sets sign flag, counter=0, goes to CALC, o_busy<=1.
  - In signed mode, |op1| and |op2| are latched and sign flag = op1[31]^op2[31].
  - In unsigned mode, raw operands are latched and sign flag = 0.
- CALC, edges 1..WIDTH:
  - If acc_lo[0]=1: {carry,sum} = acc_hi + mcand (33-bit). Else {carry,sum} = {0,acc_hi}.
  - Then {acc_hi,acc_lo} <= {carry,sum,acc_lo} >> 1.
  - counter increments each edge. On the edge where counter=WIDTH-1, go to FIX.
- FIX, edge WIDTH+1:
  - If sign flag=1, write the 64-bit two's-complement negation of {acc_hi,acc_lo}; else write it as-is.
  - Writes go to o_hi/o_lo, with o_done<=1, o_busy<=0, state->IDLE.

Latency and outputs:
- Fixed latency: o_done is high exactly 33 cycles after the accepting edge. It does not depend on data.
- o_done is high for exactly one cycle.
- o_hi/o_lo hold their value until the next FIX write or reset. They do not change during CALC.

Boundary conditions:
- i_start while busy is ignored. Operands and state are unaffected, and the request is not queued.
- i_start in the cycle o_done is high is accepted, because state is IDLE. Back-to-back throughput is one result per 34 cycles.
- Operands may change after the accepting edge without effect.
- |-2^31| = 0x8000_0000 is treated as an unsigned magnitude, so the product is correct (no overflow case).
- The accumulator carry-out is kept in the 33-bit shift. No overflow flag exists; the 64-bit result is always exact.

Optional Feature:
- Macro: MULT_UNIT_SIGNED_EN.
- Defined:
  - i_signed is honoured, with magnitude conversion on accept and negation in FIX as above.
- Undefined:
  - i_signed is ignored (port kept, left unconnected internally) and sign flag is forced to 0.
  - All operations are MULTU; the FIX state still exists, so latency stays 33.
  - The absolute-value and negation logic is removed.

Test Plan:
1. Reset 2 cycles; i_op1=7, i_op2=6, i_signed=0, start 1 cycle -> o_done exactly 33 cycles later, o_hi=0x00000000, o_lo=0x0000002A; o_busy high for cycles 1..32 after the accepting edge.
2. Unsigned 0xFFFFFFFF*0xFFFFFFFF -> o_hi=0xFFFFFFFE, o_lo=0x00000001.
3. i_op1=-12 (0xFFFFFFF4), i_op2=15, i_signed=1:
   - With MULT_UNIT_SIGNED_EN: o_hi=0xFFFFFFFF, o_lo=0xFFFFFF4C.
   - Without it: o_hi=0x0000000E, o_lo=0xFFFFFF4C.
4. Signed 0x80000000*0xFFFFFFFF (macro on) -> o_hi=0x00000000, o_lo=0x80000000.
5. Start 3*5; pulse start with 9*9 at cycle 10 -> a single o_done, at cycle 33, result 15. Then start 9*9 in the o_done cycle -> a second o_done 33 cycles later with result 81.
6. Start 100*100; assert i_rst at cycle 20 -> next cycle o_busy=0, o_hi=o_lo=0, and no o_done appears within 40 cycles.

Source files
------------

// File: rtl/mult_unit.sv
// ============================================================================
// Module   : mult_unit
// Purpose  : Iterative radix-2 shift-add 32x32->64 multiplier for MULT/MULTU.
//            Signed support is built only when MULT_UNIT_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_result;
  logic [WIDTH-1:0]   w_op1_mag;
  logic [WIDTH-1:0]   w_op2_mag;

`ifdef MULT_UNIT_SIGNED_EN
  logic neg_q, neg_d;
  logic w_sign_in;

  // Magnitudes are unsigned, so |-2^31| = 0x8000_0000 needs no special case.
  assign w_op1_mag = (i_signed && i_op1[WIDTH-1]) ? -i_op1 : i_op1;
  assign w_op2_mag = (i_signed && i_op2[WIDTH-1]) ? -i_op2 : i_op2;
  assign w_sign_in = i_signed & (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
  assign w_result  = neg_q ? -w_prod : w_prod;
`else
  logic w_unused_signed;

  assign w_unused_signed = i_signed;
  assign w_op1_mag       = i_op1;
  assign w_op2_mag       = i_op2;
  assign w_result        = w_prod;
`endif

  // Carry-out is kept as the new MSB of the shifted accumulator.
  assign w_sum  = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, mcand_q})
                              : {1'b0, acc_hi_q};
  assign w_prod = {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MULT_UNIT_SIGNED_EN
    neg_d    = neg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mcand_d  = w_op1_mag;
          acc_lo_d = w_op2_mag;
          acc_hi_d = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_CALC;
`ifdef MULT_UNIT_SIGNED_EN
          neg_d    = w_sign_in;
`endif
        end
      end

      S_CALC: begin
        acc_hi_d = w_sum[WIDTH:1];
        acc_lo_d = {w_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        hi_d    = w_result[2*WIDTH-1:WIDTH];
        lo_d    = w_result[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULT_UNIT_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULT_UNIT_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_unit.sv
// ============================================================================
// Module   : tb_mult_unit
// Purpose  : Directed self-checking bench for mult_unit (MULT_UNIT_SIGNED_EN
//            selects the signed-mode expectations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] op1;
  logic [31:0] op2;
  wire         busy;
  wire         done;
  wire  [31:0] hi;
  wire  [31:0] lo;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mult_unit #(.WIDTH(32)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_signed (sgn),
    .i_op1    (op1),
    .i_op2    (op2),
    .o_busy   (busy),
    .o_done   (done),
    .o_hi     (hi),
    .o_lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one operation and waits (bounded) for o_done; returns observations.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output int lat, output int busy_errs);
    op1 = a; op2 = b; sgn = s; start = 1'b1;
    tick();
    start = 1'b0;
    op1 = 32'h5A5A_5A5A; op2 = 32'hA5A5_A5A5; sgn = ~s;
    lat = -1; rhi = '0; rlo = '0; busy_errs = 0;
    if (busy !== 1'b1) busy_errs++;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n; rhi = hi; rlo = lo;
        break;
      end
      if (busy !== 1'b1) busy_errs++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; op1 = '0; op2 = '0;
    tick();
    tick();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h expected 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h expected 0", lo); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] rhi, rlo;
    int lat, berr;
    run_op(32'd7, 32'd6, 1'b0, rhi, rlo, lat, berr);
    total_cnt++; if (lat !== 33) $display("FAIL basic_latency: got %0d expected 33", lat); else pass_cnt++;
    total_cnt++; if (berr !== 0) $display("FAIL basic_busy: got %0d low cycles expected 0", berr); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (rhi !== 32'h0000_0000) $display("FAIL basic_hi: got %h expected 00000000", rhi); else pass_cnt++;
    total_cnt++; if (rlo !== 32'h0000_002A) $display("FAIL basic_lo: got %h expected 0000002a", rlo); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0000_002A) $display("FAIL basic_lo_hold: got %h expected 0000002a", lo); else pass_cnt++;
  endtask

  task automatic test_unsigned_max();
    logic [31:0] rhi, rlo;
    int lat, berr;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rhi, rlo, lat, berr);
    total_cnt++; if (lat !== 33) $display("FAIL umax_latency: got %0d expected 33", lat); else pass_cnt++;
    total_cnt++; if (rhi !== 32'hFFFF_FFFE) $display("FAIL umax_hi: got %h expected fffffffe", rhi); else pass_cnt++;
    total_cnt++; if (rlo !== 32'h0000_0001) $display("FAIL umax_lo: got %h expected 00000001", rlo); else pass_cnt++;
  endtask

  task automatic test_signed_mixed();
    logic [31:0] rhi, rlo, ehi;
    int lat, berr;
`ifdef MULT_UNIT_SIGNED_EN
    ehi = 32'hFFFF_FFFF;
`else
    ehi = 32'h0000_000E;
`endif
    run_op(32'hFFFF_FFF4, 32'd15, 1'b1, rhi, rlo, lat, berr);
    total_cnt++; if (lat !== 33) $display("FAIL smix_latency: got %0d expected 33", lat); else pass_cnt++;
    total_cnt++; if (rhi !== ehi) $display("FAIL smix_hi: got %h expected %h", rhi, ehi); else pass_cnt++;
    total_cnt++; if (rlo !== 32'hFFFF_FF4C) $display("FAIL smix_lo: got %h expected ffffff4c", rlo); else pass_cnt++;
  endtask

  task automatic test_signed_minint();
    logic [31:0] rhi, rlo, ehi;
    int lat, berr;
`ifdef MULT_UNIT_SIGNED_EN
    ehi = 32'h0000_0000;
`else
    ehi = 32'h7FFF_FFFF;
`endif
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, rhi, rlo, lat, berr);
    total_cnt++; if (lat !== 33) $display("FAIL smin_latency: got %0d expected 33", lat); else pass_cnt++;
    total_cnt++; if (rhi !== ehi) $display("FAIL smin_hi: got %h expected %h", rhi, ehi); else pass_cnt++;
    total_cnt++; if (rlo !== 32'h8000_0000) $display("FAIL smin_lo: got %h expected 80000000", rlo); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int dcount = 0;
    int first  = -1;
    logic [31:0] rhi, rlo;
    op1 = 32'd3; op2 = 32'd5; sgn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      if (n == 10) begin
        op1 = 32'd9; op2 = 32'd9; start = 1'b1;
      end
      tick();
      if (n == 10) start = 1'b0;
      if (done === 1'b1) begin
        dcount++;
        if (first < 0) first = n;
      end
    end
    total_cnt++; if (dcount !== 1) $display("FAIL b2b_done_count: got %0d expected 1", dcount); else pass_cnt++;
    total_cnt++; if (first !== 33) $display("FAIL b2b_first_done: got %0d expected 33", first); else pass_cnt++;
    total_cnt++; if (lo !== 32'd15) $display("FAIL b2b_first_lo: got %0d expected 15", lo); else pass_cnt++;
    total_cnt++; if (hi !== 32'd0) $display("FAIL b2b_first_hi: got %h expected 0", hi); else pass_cnt++;
    // Start is raised while o_done is high, so the next edge accepts it.
    op1 = 32'd9; op2 = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    op1 = 32'd0; op2 = 32'd0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept_busy: got %b expected 1", busy); else pass_cnt++;
    first = -1; rhi = '0; rlo = '0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done === 1'b1) begin
        first = n; rhi = hi; rlo = lo;
        break;
      end
    end
    total_cnt++; if (first !== 33) $display("FAIL b2b_second_done: got %0d expected 33", first); else pass_cnt++;
    total_cnt++; if (rlo !== 32'd81) $display("FAIL b2b_second_lo: got %0d expected 81", rlo); else pass_cnt++;
    total_cnt++; if (rhi !== 32'd0) $display("FAIL b2b_second_hi: got %h expected 0", rhi); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_abort();
    int dcount = 0;
    op1 = 32'd100; op2 = 32'd100; sgn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 19; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (hi !== 32'h0) $display("FAIL abort_hi: got %h expected 0", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h0) $display("FAIL abort_lo: got %h expected 0", lo); else pass_cnt++;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    total_cnt++; if (dcount !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", dcount); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; op1 = '0; op2 = '0;
    test_reset();
    test_basic();
    test_unsigned_max();
    test_signed_mixed();
    test_signed_minint();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
